lsu: RTL and testbench

Load/store unit sitting directly downstream of the CPU's integer ALU: consumes the ALU result as an effective address and performs one RISC-V load or store per transaction over a simple req/gnt/rvalid data-memory bus. Handles byte-lane steering, sign/zero extension, misalignment and illegal-width detection, and bus timeout. Returns a one-cycle completion pulse with writeback data to the register-file stage.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 54 +++++
 rtl/lsu.sv | 222 ++++++++++++++++++++++
 tb/tb_lsu.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, types and operation checks for the load/store unit.
// Width codes follow the RISC-V funct3 encoding for loads and stores.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Illegal width wins over misalignment; unsigned widths are load-only.
  function automatic logic [1:0] check_op(input logic [2:0] funct3,
                                          input logic       we,
                                          input logic [1:0] addr_lo);
    logic [1:0] err;
    err = ERR_OK;
    case (funct3)
      F3_B, F3_BU: err = ERR_OK;
      F3_H, F3_HU: err = addr_lo[0] ? ERR_MISALIGN : ERR_OK;
      F3_W:        err = (addr_lo != 2'b00) ? ERR_MISALIGN : ERR_OK;
      default:     err = ERR_ILLEGAL;
    endcase
    if (we && funct3[2]) begin
      err = ERR_ILLEGAL;
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and data replication, plus load
// lane extraction with sign or zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_rdata_o
);

  logic [31:0] lane;

  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = st_wdata_i;
    case (st_funct3_i)
      F3_B, F3_BU: begin
        st_be_o    = 4'b0001 << st_addr_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      F3_W: begin
        st_be_o    = 4'b1111;
      end
      default: begin
        st_be_o    = 4'b0000;
      end
    endcase
  end

  // The addressed byte or halfword is shifted down to bit 0 first.
  assign lane = ld_rdata_i >> {ld_addr_i, 3'b000};

  always_comb begin
    ld_rdata_o = lane;
    case (ld_funct3_i)
      F3_B:    ld_rdata_o = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   ld_rdata_o = {24'h000000, lane[7:0]};
      F3_H:    ld_rdata_o = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   ld_rdata_o = {16'h0000, lane[15:0]};
      default: ld_rdata_o = lane;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one RISC-V load or store per transaction over a
// req/gnt/rvalid bus, with error detection, bus timeout and a done pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  output logic        done_o,
  output logic        wb_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  rd_o,
  output logic [1:0]  err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  // Counter holds cycles already spent in the current phase; abort on the
  // cycle that would be the TIMEOUT_CYCLES-th.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             we_q, we_d;
  logic [4:0]       rd_lat_q, rd_lat_d;

  logic             done_q, done_d;
  logic             wb_q, wb_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [4:0]       rd_q, rd_d;
  logic [1:0]       err_q, err_d;

  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             mem_we_q, mem_we_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic [1:0]       op_err;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_rdata;

  assign op_err = check_op(funct3_i, we_i, addr_i[1:0]);

  // Store steering uses the op being accepted; load formatting uses the
  // op latched at acceptance.
  lsu_align u_align (
    .st_funct3_i (funct3_i),
    .st_addr_i   (addr_i[1:0]),
    .st_wdata_i  (wdata_i),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (funct3_q),
    .ld_addr_i   (addr_lo_q),
    .ld_rdata_i  (mem_rdata_i),
    .ld_rdata_o  (ld_rdata)
  );

  /*
   * Upstream handshake: an op transfers on a rising edge where valid_i and
   * ready_o are both high; ready_o is high exactly when the FSM is IDLE.
   * Bus handshake: mem_req_o and every bus field stay stable from the first
   * request cycle until the edge that samples mem_gnt_i high; the response
   * is the first mem_rvalid_i seen after the grant.
   */
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    rd_lat_d    = rd_lat_q;
    done_d      = 1'b0;
    wb_d        = 1'b0;
    rdata_d     = rdata_q;
    rd_d        = rd_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          addr_lo_d = addr_i[1:0];
          funct3_d  = funct3_i;
          we_d      = we_i;
          rd_lat_d  = rd_i;
          if (op_err != ERR_OK) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = op_err;
            rdata_d = 32'h0;
            rd_d    = rd_i;
          end else begin
            state_d     = ST_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_we_d    = we_i;
            mem_be_d    = st_be;
            mem_wdata_d = we_i ? st_wdata : 32'h0;
          end
        end
      end

      ST_REQ: begin
        if (mem_gnt_i) begin
          state_d   = ST_WAIT;
          cnt_d     = '0;
          mem_req_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = ERR_TIMEOUT;
          rdata_d   = 32'h0;
          rd_d      = rd_lat_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          wb_d    = ~we_q;
          err_d   = ERR_OK;
          rdata_d = we_q ? 32'h0 : ld_rdata;
          rd_d    = rd_lat_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = ERR_TIMEOUT;
          rdata_d = 32'h0;
          rd_d    = rd_lat_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      rd_lat_q    <= 5'd0;
      done_q      <= 1'b0;
      wb_q        <= 1'b0;
      rdata_q     <= 32'h0;
      rd_q        <= 5'd0;
      err_q       <= ERR_OK;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      rd_lat_q    <= rd_lat_d;
      done_q      <= done_d;
      wb_q        <= wb_d;
      rdata_q     <= rdata_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign done_o      = done_q;
  assign wb_o        = wb_q;
  assign rdata_o     = rdata_q;
  assign rd_o        = rd_q;
  assign err_o       = err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: each step drives one op, plays the bus slave and
// compares the completion against hand-computed values.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        done_o;
  logic        wb_o;
  logic [31:0] rdata_o;
  logic [4:0]  rd_o;
  logic [1:0]  err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .we_i         (we_i),
    .funct3_i     (funct3_i),
    .rd_i         (rd_i),
    .done_o       (done_o),
    .wb_o         (wb_o),
    .rdata_o      (rdata_o),
    .rd_o         (rd_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_we;
  bit          saw_req;
  bit          bus_stable;
  logic        req_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!ready_o && guard < 20) begin
      step();
      guard++;
    end
    check({tag, ".ready"}, 32'(ready_o), 32'd1);
  endtask

  // gnt_dly: request cycles to withhold the grant (-1 = never grant).
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int gnt_dly,
                        input logic [31:0] rdata, input logic [1:0] exp_err,
                        input logic [31:0] exp_rdata, input int exp_cyc);
    int          cyc;
    int          req_cyc;
    bit          granted;
    bit          got_done;
    logic [31:0] exp_v;
    wait_ready(tag);
    exp_q.push_back(exp_rdata);
    valid_i  = 1'b1;
    we_i     = we;
    funct3_i = f3;
    addr_i   = addr;
    wdata_i  = wdata;
    rd_i     = rd;
    step();
    valid_i  = 1'b0;
    cyc        = 1;
    req_cyc    = 0;
    granted    = 1'b0;
    got_done   = 1'b0;
    saw_req    = 1'b0;
    bus_stable = 1'b1;
    while (!got_done && cyc < 40) begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = granted;
      mem_rdata_i  = granted ? rdata : 32'hA5A5_A5A5;
      granted      = 1'b0;
      if (done_o) begin
        got_done    = 1'b1;
        req_at_done = mem_req_o;
      end else begin
        if (mem_req_o) begin
          if (!saw_req) begin
            bus_addr  = mem_addr_o;
            bus_be    = mem_be_o;
            bus_wdata = mem_wdata_o;
            bus_we    = mem_we_o;
          end else if ({mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o} !==
                       {bus_addr, bus_be, bus_wdata, bus_we}) begin
            bus_stable = 1'b0;
          end
          saw_req = 1'b1;
          if (gnt_dly >= 0 && req_cyc == gnt_dly) begin
            mem_gnt_i = 1'b1;
            granted   = 1'b1;
          end
          req_cyc++;
        end
        step();
        cyc++;
      end
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    exp_v = exp_q.pop_front();
    check({tag, ".done"},  32'(got_done), 32'd1);
    check({tag, ".cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, ".err"},   32'(err_o), 32'(exp_err));
    check({tag, ".rdata"}, rdata_o, exp_v);
    check({tag, ".wb"},    32'(wb_o), 32'(!we && exp_err == ERR_OK));
    check({tag, ".rd"},    32'(rd_o), 32'(rd));
    step();
    check({tag, ".pulse"}, 32'(done_o), 32'd0);
    check({tag, ".idle"},  32'(ready_o), 32'd1);
  endtask

  task automatic check_bus(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic exp_we);
    check({tag, ".req"}, 32'(saw_req), 32'(exp_req));
    if (exp_req) begin
      check({tag, ".maddr"},  bus_addr, exp_addr);
      check({tag, ".be"},     32'(bus_be), 32'(exp_be));
      check({tag, ".mwdata"}, bus_wdata, exp_wdata);
      check({tag, ".mwe"},    32'(bus_we), 32'(exp_we));
      check({tag, ".stable"}, 32'(bus_stable), 32'd1);
    end
  endtask

  task automatic start_lw(input logic [31:0] addr);
    wait_ready("start");
    valid_i  = 1'b1;
    we_i     = 1'b0;
    funct3_i = F3_W;
    addr_i   = addr;
    wdata_i  = 32'h0;
    rd_i     = 5'd1;
    step();
    valid_i  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n        = 1'b0;
    valid_i      = 1'b0;
    addr_i       = 32'h0;
    wdata_i      = 32'h0;
    we_i         = 1'b0;
    funct3_i     = 3'b000;
    rd_i         = 5'd0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    req_at_done  = 1'b0;
    repeat (3) step();
    check("rst.ready", 32'(ready_o), 32'd1);
    check("rst.done",  32'(done_o), 32'd0);
    check("rst.req",   32'(mem_req_o), 32'd0);
    check("rst.err",   32'(err_o), 32'd0);
    check("rst.rdata", rdata_o, 32'h0);
    check("rst.be",    32'(mem_be_o), 32'd0);
    rst_n = 1'b1;
    step();

    run_op("sw", 1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 5'd5, 0, 32'h0, ERR_OK, 32'h0, 3);
    check_bus("sw", 1'b1, 32'h100, 4'b1111, 32'hDEAD_BEEF, 1'b1);

    run_op("lb", 1'b0, F3_B, 32'h103, 32'h0, 5'd7, 0, 32'h8011_2233, ERR_OK, 32'hFFFF_FF80, 3);
    check_bus("lb", 1'b1, 32'h100, 4'b1000, 32'h0, 1'b0);
    run_op("lbu", 1'b0, F3_BU, 32'h103, 32'h0, 5'd8, 0, 32'h8011_2233, ERR_OK, 32'h0000_0080, 3);
    run_op("lh", 1'b0, F3_H, 32'h102, 32'h0, 5'd9, 0, 32'h8011_2233, ERR_OK, 32'hFFFF_8011, 3);
    check_bus("lh", 1'b1, 32'h100, 4'b1100, 32'h0, 1'b0);
    run_op("lhu", 1'b0, F3_HU, 32'h100, 32'h0, 5'd10, 0, 32'h1234_F00D, ERR_OK, 32'h0000_F00D, 3);

    run_op("sh", 1'b1, F3_H, 32'h202, 32'h0000_ABCD, 5'd11, 0, 32'h0, ERR_OK, 32'h0, 3);
    check_bus("sh", 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1);
    run_op("sb", 1'b1, F3_B, 32'h201, 32'h0000_005A, 5'd12, 0, 32'h0, ERR_OK, 32'h0, 3);
    check_bus("sb", 1'b1, 32'h200, 4'b0010, 32'h5A5A_5A5A, 1'b1);

    run_op("lw_mis", 1'b0, F3_W, 32'h101, 32'h0, 5'd13, 0, 32'h0, ERR_MISALIGN, 32'h0, 1);
    check_bus("lw_mis", 1'b0, 32'h0, 4'b0, 32'h0, 1'b0);
    run_op("sh_mis", 1'b1, F3_H, 32'h203, 32'h1234, 5'd14, 0, 32'h0, ERR_MISALIGN, 32'h0, 1);
    check_bus("sh_mis", 1'b0, 32'h0, 4'b0, 32'h0, 1'b0);
    run_op("f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 5'd15, 0, 32'h0, ERR_ILLEGAL, 32'h0, 1);
    check_bus("f3_011", 1'b0, 32'h0, 4'b0, 32'h0, 1'b0);
    run_op("sbu_ill", 1'b1, F3_BU, 32'h100, 32'h55, 5'd16, 0, 32'h0, ERR_ILLEGAL, 32'h0, 1);
    run_op("ill_mis", 1'b0, 3'b110, 32'h101, 32'h0, 5'd17, 0, 32'h0, ERR_ILLEGAL, 32'h0, 1);

    run_op("lw_slow", 1'b0, F3_W, 32'h104, 32'h0, 5'd18, 3, 32'hCAFE_F00D, ERR_OK, 32'hCAFE_F00D, 6);
    check_bus("lw_slow", 1'b1, 32'h104, 4'b1111, 32'h0, 1'b0);

    run_op("tmo", 1'b0, F3_W, 32'h400, 32'h0, 5'd19, -1, 32'h0, ERR_TIMEOUT, 32'h0, 5);
    check("tmo.req_drop", 32'(req_at_done), 32'd0);
    check_bus("tmo", 1'b1, 32'h400, 4'b1111, 32'h0, 1'b0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    step();
    mem_rvalid_i = 1'b0;
    check("late.done",  32'(done_o), 32'd0);
    check("late.ready", 32'(ready_o), 32'd1);
    check("late.rdata", rdata_o, 32'h0);
    run_op("after_tmo", 1'b0, F3_B, 32'h100, 32'h0, 5'd20, 0, 32'h0000_007F, ERR_OK, 32'h0000_007F, 3);

    start_lw(32'h300);
    check("rst_req.before", 32'(mem_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_req.req",   32'(mem_req_o), 32'd0);
    check("rst_req.done",  32'(done_o), 32'd0);
    check("rst_req.ready", 32'(ready_o), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    start_lw(32'h300);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    check("rst_wait.busy", 32'(ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_wait.req",   32'(mem_req_o), 32'd0);
    check("rst_wait.done",  32'(done_o), 32'd0);
    check("rst_wait.ready", 32'(ready_o), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("rst_wait.after", 32'(ready_o), 32'd1);

    run_op("after_rst", 1'b0, F3_H, 32'h102, 32'h0, 5'd21, 0, 32'h7FFF_0000, ERR_OK, 32'h0000_7FFF, 3);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
